mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 71 +++++++
 rtl/mem_access_load_align.sv | 41 ++++
 rtl/mem_access.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the memory-access (ME) stage: register bus widths,
// the NOP register address, the zero word, the mem_op encodings and small
// decode helpers used by mem_access and load_align.
// ---------------------------------------------------------------------------
package mem_access_pkg;

    localparam int RegBus     = 32;  // register / data word width
    localparam int RegAddrBus = 5;   // register file address width

    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic [RegBus-1:0]     ZeroWord   = '0;

    // mem_op encodings
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

    // Byte enables of the lanes touched by an access.
    function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [1:0] off);
        logic [3:0] be;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << off;
            MEM_LH, MEM_LHU, MEM_SH: be = 4'b0011 << {off[1], 1'b0};
            default:                 be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables pick the right one.
    function automatic logic [RegBus-1:0] store_lanes(input logic [3:0] op,
                                                      input logic [RegBus-1:0] data);
        logic [RegBus-1:0] w;
        case (op)
            MEM_SB:  w = {4{data[7:0]}};
            MEM_SH:  w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data extraction. Selects the byte (offset[1:0]) or
// halfword (offset[1]) lane from the memory read word and sign- or
// zero-extends it; LW returns the whole word.
// Ports:
//   rdata  in  32  read word from memory
//   offset in  2   low address bits of the access
//   op     in  4   mem_op encoding
//   result out 32  extracted, extended load value
// ---------------------------------------------------------------------------
module load_align
    import mem_access_pkg::*;
(
    input  logic [RegBus-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [3:0]        op,
    output logic [RegBus-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = rdata[{offset[1], 4'b0000} +: 16];

    // NOTE: every output of a combinational block gets a value on every path
    // (here via the case default); a missing assignment infers a latch.
    always_comb begin
        result = ZeroWord;
        case (op)
            MEM_LB:  result = {{24{byte_lane[7]}}, byte_lane};
            MEM_LBU: result = {24'd0, byte_lane};
            MEM_LH:  result = {{16{half_lane[15]}}, half_lane};
            MEM_LHU: result = {16'd0, half_lane};
            MEM_LW:  result = rdata;
            default: result = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// ME stage of the pipeline. ALU results pass to the ME/WB register with one
// cycle latency; loads and stores issue a single memory request, stall the
// upstream stage until mem_ack_i, then write back the aligned load data
// (stores write nothing back). Every edge that does not complete an op loads
// a bubble into the ME/WB register.
//
// Configuration macro: MEM_MISALIGN_CHECK_EN
//   defined   - adds misalign_o; misaligned LH/LHU/SH/LW/SW issue no request,
//               do not stall, pulse misalign_o for one cycle and yield a bubble.
//   undefined - no misalign_o; halfword uses addr[1], word ignores addr[1:0].
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   valid_i                        EX result present
//   w_enable_i/w_addr_i/w_data_i   EX writeback intent, rd, ALU result/address
//   mem_op_i, store_data_i         memory op, rs2 store value
//   stall_o                        upstream holds inputs while high
//   mem_req_o/mem_we_o             memory request and write strobe
//   mem_addr_o/mem_wdata_o/mem_be_o word address, lane data, byte enables
//   mem_ack_i/mem_rdata_i          completion and read word
//   w_enable_o/w_addr_o/w_data_o   registered ME/WB result
//   misalign_o                     misaligned-access pulse (macro only)
// ---------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  w_enable_i,
    input  logic [RegAddrBus-1:0] w_addr_i,
    input  logic [RegBus-1:0]     w_data_i,
    input  logic [3:0]            mem_op_i,
    input  logic [RegBus-1:0]     store_data_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [RegBus-1:0]     mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [RegBus-1:0]     mem_rdata_i,
    output logic                  w_enable_o,
    output logic [RegAddrBus-1:0] w_addr_o,
    output logic [RegBus-1:0]     w_data_o
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]            state;
    logic [3:0]            op_q;
    logic [RegAddrBus-1:0] dest_q;
    logic                  wen_q;
    logic [1:0]            off_q;

    logic [ADDR_W-1:0]     eff_addr;
    logic [1:0]            offset;
    logic                  misalign;
    logic                  start_mem;
    logic [RegBus-1:0]     load_result;

    assign eff_addr = ADDR_W'(w_data_i);
    assign offset   = w_data_i[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = valid_i && is_misaligned(mem_op_i, offset);
`else
    assign misalign = 1'b0;
`endif

    assign start_mem = valid_i && is_mem(mem_op_i) && !misalign;

    // Stall is raised in the same cycle a memory op is presented so upstream
    // holds it, and stays up in BUSY until the ack cycle.
    assign stall_o = (state == ST_IDLE) ? start_mem : !mem_ack_i;

    load_align u_load_align (
        .rdata  (mem_rdata_i),
        .offset (off_q),
        .op     (op_q),
        .result (load_result)
    );

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= MEM_NONE;
            dest_q      <= NOPRegAddr;
            wen_q       <= 1'b0;
            off_q       <= 2'b00;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= ZeroWord;
            mem_be_o    <= 4'b0000;
            w_enable_o  <= 1'b0;
            w_addr_o    <= NOPRegAddr;
            w_data_o    <= ZeroWord;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
            // Bubble unless this edge completes an op.
            w_enable_o <= 1'b0;
            w_addr_o   <= NOPRegAddr;
            w_data_o   <= ZeroWord;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_o <= (state == ST_IDLE) && misalign;
`endif
            case (state)
                ST_IDLE: begin
                    if (start_mem) begin
                        state       <= ST_BUSY;
                        op_q        <= mem_op_i;
                        dest_q      <= w_addr_i;
                        wen_q       <= w_enable_i;
                        off_q       <= offset;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= is_store(mem_op_i);
                        mem_addr_o  <= {eff_addr[ADDR_W-1:2], 2'b00};
                        mem_be_o    <= lane_be(mem_op_i, offset);
                        mem_wdata_o <= is_store(mem_op_i)
                                       ? store_lanes(mem_op_i, store_data_i) : ZeroWord;
                    end else if (valid_i && !is_mem(mem_op_i)) begin
                        w_enable_o <= w_enable_i;
                        w_addr_o   <= w_addr_i;
                        w_data_o   <= w_data_i;
                    end
                end
                ST_BUSY: begin
                    // mem_* registers are left untouched until the ack edge.
                    if (mem_ack_i) begin
                        state       <= ST_IDLE;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= '0;
                        mem_wdata_o <= ZeroWord;
                        mem_be_o    <= 4'b0000;
                        if (is_load(op_q)) begin
                            w_enable_o <= wen_q;
                            w_addr_o   <= dest_q;
                            w_data_o   <= load_result;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
